// File: rtl/dm_cache_controller.sv
// Sequencer for a direct-mapped write-back cache: hit check, dirty victim writeback,
// line refill and request replay against an external data array and a block memory port.
module dm_cache_controller #(
  parameter int TAG_W   = 3,
  parameter int INDEX_W = 10,
  parameter int OFF_W   = 4,
  parameter int DATA_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_req_valid,
  output logic                             cpu_req_ready,
  input  logic                             cpu_req_we,
  input  logic [TAG_W+INDEX_W+OFF_W-1:0]   cpu_req_addr,
  input  logic [DATA_W-1:0]                cpu_req_wdata,
  output logic                             cpu_resp_valid,
  output logic [DATA_W-1:0]                cpu_resp_rdata,
  output logic [INDEX_W+OFF_W-1:0]         da_addr,
  output logic                             da_we,
  output logic [DATA_W-1:0]                da_wdata,
  input  logic [DATA_W-1:0]                da_rdata,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_we,
  output logic [TAG_W+INDEX_W-1:0]         mem_req_blk,
  output logic                             mem_wvalid,
  input  logic                             mem_wready,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic                             mem_rvalid,
  input  logic [DATA_W-1:0]                mem_rdata
);

  localparam int LINES  = 1 << INDEX_W;
  localparam int ADDR_W = TAG_W + INDEX_W + OFF_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_RD, WB_BEAT, RF_REQ, RF_DATA, REISSUE
  } state_t;

  state_t              state_reg;
  logic                req_we_reg;
  logic [ADDR_W-1:0]   req_addr_reg;
  logic [DATA_W-1:0]   req_wdata_reg;
  logic [OFF_W-1:0]    beat_reg;
  logic [LINES-1:0]    valid_reg;
  logic [LINES-1:0]    dirty_reg;
  logic                resp_valid_reg;
  logic [DATA_W-1:0]   resp_rdata_reg;
  logic [TAG_W-1:0]    tag_mem [LINES];

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFF_W-1:0]    req_off;
  logic [TAG_W-1:0]    line_tag;
  logic                hit;
  logic                last_beat;
  logic                tag_we;

  assign req_tag   = req_addr_reg[ADDR_W-1 -: TAG_W];
  assign req_idx   = req_addr_reg[OFF_W +: INDEX_W];
  assign req_off   = req_addr_reg[OFF_W-1:0];
  assign line_tag  = tag_mem[req_idx];
  assign hit       = valid_reg[req_idx] && (line_tag == req_tag);
  assign last_beat = (beat_reg == {OFF_W{1'b1}});
  assign tag_we    = !rst && (state_reg == RF_DATA) && mem_rvalid && last_beat;

  // Tags are never reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (tag_we)
      tag_mem[req_idx] <= req_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      valid_reg      <= '0;
      dirty_reg      <= '0;
      beat_reg       <= '0;
      req_we_reg     <= 1'b0;
      req_addr_reg   <= '0;
      req_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (cpu_req_valid) begin
            req_we_reg    <= cpu_req_we;
            req_addr_reg  <= cpu_req_addr;
            req_wdata_reg <= cpu_req_wdata;
            state_reg     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= req_we_reg ? '0 : da_rdata;
            if (req_we_reg)
              dirty_reg[req_idx] <= 1'b1;
            state_reg <= IDLE;
          end else if (valid_reg[req_idx] && dirty_reg[req_idx]) begin
            state_reg <= WB_REQ;
          end else begin
            state_reg <= RF_REQ;
          end
        end
        WB_REQ: begin
          if (mem_req_ready) begin
            beat_reg  <= '0;
            state_reg <= WB_RD;
          end
        end
        WB_RD: state_reg <= WB_BEAT;
        WB_BEAT: begin
          if (mem_wready) begin
            if (last_beat) begin
              dirty_reg[req_idx] <= 1'b0;
              state_reg          <= RF_REQ;
            end else begin
              beat_reg  <= beat_reg + 1'b1;
              state_reg <= WB_RD;
            end
          end
        end
        RF_REQ: begin
          if (mem_req_ready) begin
            beat_reg  <= '0;
            state_reg <= RF_DATA;
          end
        end
        RF_DATA: begin
          if (mem_rvalid) begin
            if (last_beat) begin
              valid_reg[req_idx] <= 1'b1;
              dirty_reg[req_idx] <= 1'b0;
              state_reg          <= REISSUE;
            end else begin
              beat_reg <= beat_reg + 1'b1;
            end
          end
        end
        REISSUE: state_reg <= LOOKUP;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cpu_req_ready  = (state_reg == IDLE);
  assign cpu_resp_valid = resp_valid_reg;
  assign cpu_resp_rdata = resp_rdata_reg;

  // Data array address is steered combinationally so the synchronous read lands in LOOKUP.
  always_comb begin
    da_addr       = {req_idx, req_off};
    da_we         = 1'b0;
    da_wdata      = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_blk   = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    case (state_reg)
      IDLE: da_addr = cpu_req_addr[INDEX_W+OFF_W-1:0];
      LOOKUP: begin
        if (hit && req_we_reg) begin
          da_we    = 1'b1;
          da_wdata = req_wdata_reg;
        end
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_blk   = {line_tag, req_idx};
      end
      WB_RD: da_addr = {req_idx, beat_reg};
      WB_BEAT: begin
        // Holding the address keeps da_rdata stable while the beat is stalled.
        da_addr    = {req_idx, beat_reg};
        mem_wvalid = 1'b1;
        mem_wdata  = da_rdata;
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_blk   = {req_tag, req_idx};
      end
      RF_DATA: begin
        da_addr = {req_idx, beat_reg};
        if (mem_rvalid) begin
          da_we    = 1'b1;
          da_wdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
